// File: rtl/gemm_mmio_bridge_pkg.sv
// Shared types and constants for the GEMM MMIO bridge:
// register map, descriptor bundle, FSM states, STATUS bits.
package gemm_bridge_pkg;

   localparam logic [4:0] OFF_A       = 5'h00;
   localparam logic [4:0] OFF_B       = 5'h04;
   localparam logic [4:0] OFF_C       = 5'h08;
   localparam logic [4:0] OFF_DIM     = 5'h0C;
   localparam logic [4:0] OFF_CMD     = 5'h10;
   localparam logic [4:0] OFF_STATUS  = 5'h14;
   localparam logic [4:0] OFF_IRQ_EN  = 5'h18;
   localparam logic [4:0] OFF_IRQ_CLR = 5'h1C;

   localparam int ST_FULL     = 0;
   localparam int ST_EMPTY    = 1;
   localparam int ST_OVF      = 2;
   localparam int ST_BUSY     = 3;
   localparam int ST_DONE_LSB = 8;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [23:0] dim;
   } desc_t;

   typedef enum logic {
      IDLE,
      RESP
   } state_t;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] wd,
      input logic [3:0]  m
   );
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/gemm_mmio_bridge_if.sv
// Core load/store port as seen by the bridge.
// master = core side, slave = bridge side.
interface gemm_mmio_bridge_if;
   logic        cs;
   logic        mem_rd_wr;
   logic [3:0]  mask;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        mem_valid;

   modport master (
      output cs, mem_rd_wr, mask, mem_addr, mem_write_data,
      input  mem_read_data, mem_valid
   );

   modport slave (
      input  cs, mem_rd_wr, mask, mem_addr, mem_write_data,
      output mem_read_data, mem_valid
   );
endinterface

// File: rtl/gemm_mmio_bridge_cmd_fifo.sv
// Synchronous descriptor FIFO; head is shown only when non-empty.
// A push while full is accepted only if a pop frees a slot the same cycle.
module cmd_fifo
   import gemm_bridge_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  desc_t       din,
   output desc_t       dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   desc_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gemm_mmio_bridge.sv
// Load/store slave that splits accesses between data RAM and the
// GEMM register window, queues descriptors and raises completion irq.
module gemm_mmio_bridge
   import gemm_bridge_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] ACC_BASE   = 32'h8000_0000,
   parameter int          RAM_AW     = 14
) (
   input  logic              clk,
   input  logic              reset,
   gemm_mmio_bridge_if.slave bus,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [3:0]        ram_mask,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              acc_cmd_valid,
   input  logic              acc_cmd_ready,
   output logic [31:0]       acc_cmd_a,
   output logic [31:0]       acc_cmd_b,
   output logic [31:0]       acc_cmd_c,
   output logic [23:0]       acc_cmd_dim,
   input  logic              acc_done,
   output logic              irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = $clog2(FIFO_DEPTH) + 2;

   state_t        state_q, state_d;
   logic          accept, rd, is_ram, is_acc, acc_wr;
   logic [4:0]    off;
   logic [31:0]   reg_rdata, status, rdata_q, dim_m;
   logic          rd_ram_q;
   logic [31:0]   a_q, b_q, c_q;
   logic [23:0]   dim_q;
   logic          irq_en_q, ovf_q, pend_q, irq_q;
   logic [7:0]    done_cnt_q;
   logic [OW-1:0] outst_q;
   logic          push, pop, full, empty, done_ok, ovf_set;
   logic [1:0]    clr;
   logic [CW-1:0] count;
   desc_t         head, new_desc;
   logic          unused_ok;

   assign rd     = bus.mem_rd_wr;
   assign off    = {bus.mem_addr[4:2], 2'b00};
   assign is_ram = (bus.mem_addr[31:RAM_AW+2] == '0);
   assign is_acc = (bus.mem_addr[31:5] == ACC_BASE[31:5]);
   assign accept = (state_q == IDLE) & bus.cs;
   assign acc_wr = accept & ~rd & is_acc;

   assign push    = acc_wr & (off == OFF_CMD);
   assign pop     = acc_cmd_valid & acc_cmd_ready;
   assign ovf_set = push & full & ~pop;
   assign done_ok = acc_done & (outst_q != '0);
   assign clr     = (acc_wr && off == OFF_IRQ_CLR && bus.mask[0])
                    ? bus.mem_write_data[1:0] : 2'b00;
   assign dim_m   = merge({8'h00, dim_q}, bus.mem_write_data, bus.mask);

   assign ram_cs    = accept & is_ram;
   assign ram_we    = ram_cs & ~rd;
   assign ram_mask  = ram_we ? bus.mask : 4'h0;
   assign ram_addr  = ram_cs ? bus.mem_addr[RAM_AW+1:2] : '0;
   assign ram_wdata = ram_we ? bus.mem_write_data : 32'h0;

   assign bus.mem_valid     = (state_q == RESP);
   assign bus.mem_read_data = (state_q == RESP)
                              ? (rd_ram_q ? ram_rdata : rdata_q) : 32'h0;

   assign new_desc      = '{a: a_q, b: b_q, c: c_q, dim: dim_q};
   assign acc_cmd_valid = ~empty;
   assign acc_cmd_a     = head.a;
   assign acc_cmd_b     = head.b;
   assign acc_cmd_c     = head.c;
   assign acc_cmd_dim   = head.dim;
   assign irq           = irq_q;

   assign unused_ok = ^{bus.mem_addr[1:0], dim_m[31:24]};

   cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (new_desc),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      status = 32'h0;
      status[ST_FULL]  = full;
      status[ST_EMPTY] = empty;
      status[ST_OVF]   = ovf_q;
      status[ST_BUSY]  = (outst_q != '0);
      status[ST_DONE_LSB +: 8] = done_cnt_q;
   end

   always_comb begin
      reg_rdata = 32'h0;
      if (is_acc) begin
         case (off)
            OFF_A:      reg_rdata = a_q;
            OFF_B:      reg_rdata = b_q;
            OFF_C:      reg_rdata = c_q;
            OFF_DIM:    reg_rdata = {8'h00, dim_q};
            OFF_CMD:    reg_rdata = 32'(count);
            OFF_STATUS: reg_rdata = status;
            OFF_IRQ_EN: reg_rdata = {31'h0, irq_en_q};
            default:    reg_rdata = 32'h0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.cs) state_d = RESP;
         RESP: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         rdata_q  <= 32'h0;
         rd_ram_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rdata_q  <= (rd && is_acc) ? reg_rdata : 32'h0;
            rd_ram_q <= rd & is_ram;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q        <= 32'h0;
         b_q        <= 32'h0;
         c_q        <= 32'h0;
         dim_q      <= 24'h0;
         irq_en_q   <= 1'b0;
         ovf_q      <= 1'b0;
         pend_q     <= 1'b0;
         irq_q      <= 1'b0;
         done_cnt_q <= 8'h0;
         outst_q    <= '0;
      end else begin
         if (acc_wr) begin
            case (off)
               OFF_A:      a_q   <= merge(a_q, bus.mem_write_data, bus.mask);
               OFF_B:      b_q   <= merge(b_q, bus.mem_write_data, bus.mask);
               OFF_C:      c_q   <= merge(c_q, bus.mem_write_data, bus.mask);
               OFF_DIM:    dim_q <= dim_m[23:0];
               OFF_IRQ_EN: if (bus.mask[0]) irq_en_q <= bus.mem_write_data[0];
               default:    ;
            endcase
         end
         // a counted completion wins over a same-cycle clear
         if (done_ok)     pend_q <= 1'b1;
         else if (clr[0]) pend_q <= 1'b0;
         if (ovf_set)     ovf_q <= 1'b1;
         else if (clr[1]) ovf_q <= 1'b0;
         if (done_ok) done_cnt_q <= done_cnt_q + 8'd1;
         case ({pop, done_ok})
            2'b10:   outst_q <= outst_q + OW'(1);
            2'b01:   outst_q <= outst_q - OW'(1);
            default: outst_q <= outst_q;
         endcase
         irq_q <= pend_q & irq_en_q;
      end
   end

endmodule
